// File: rtl/instruction_sequencer_if.sv
// rtl/instruction_sequencer_if.sv - program-load, run-control and instruction-issue signals
// The master end loads and controls the program; the slave end is the sequencer.
interface instruction_sequencer_if #(
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [2:0]    wr_op;
  logic [2:0]    wr_sel_out;
  logic [2:0]    wr_sel_in;
  logic [AW:0]   prog_len;
  logic          start;
  logic          loop;
  logic          halt;
  logic [8:0]    instruct;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;

  modport master (
    output wr_en, wr_addr, wr_op, wr_sel_out, wr_sel_in, prog_len, start, loop, halt,
    input  instruct, instr_valid, pc, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_op, wr_sel_out, wr_sel_in, prog_len, start, loop, halt,
    output instruct, instr_valid, pc, busy, done
  );
endinterface

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - program store that issues 9-bit instruction words in order
// Each entry is held on instruct for HOLD cycles; optional wrap back to entry 0.
module instruction_sequencer #(
  parameter int DEPTH = 8,
  parameter int HOLD  = 7
) (
  input logic                    clk,
  input logic                    reset,
  instruction_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q;
  logic [8:0]    mem_q [DEPTH];
  logic [8:0]    instruct_q;
  logic          valid_q;
  logic          busy_q;
  logic          done_q;
  logic [AW-1:0] pc_q;
  logic [CW-1:0] cnt_q;
  logic [AW:0]   len_q;

  logic [8:0]    wr_word_d;
  logic [8:0]    first_word_d;
  logic          wr_ok_d;
  logic          len_ok_d;
  logic          start_ok_d;
  logic          last_hold_d;
  logic          last_entry_d;
  logic [AW-1:0] pc_next_d;

  always_comb begin
    wr_word_d    = {bus.wr_op, bus.wr_sel_out, bus.wr_sel_in};
    wr_ok_d      = bus.wr_en && (state_q != RUN);
    len_ok_d     = (bus.prog_len != '0) && (bus.prog_len <= (AW+1)'(DEPTH));
    start_ok_d   = bus.start && !bus.halt && len_ok_d && (state_q != RUN);
    // A same-cycle write to entry 0 must be visible on the first issued word.
    first_word_d = (wr_ok_d && (bus.wr_addr == '0)) ? wr_word_d : mem_q[0];
    last_hold_d  = (cnt_q == CW'(HOLD - 1));
    last_entry_d = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));
    pc_next_d    = pc_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      instruct_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pc_q       <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr_ok_d) mem_q[bus.wr_addr] <= wr_word_d;
      case (state_q)
        IDLE, DONE: begin
          if (start_ok_d) begin
            state_q    <= RUN;
            instruct_q <= first_word_d;
            valid_q    <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pc_q       <= '0;
            cnt_q      <= '0;
            len_q      <= bus.prog_len;
          end else if (bus.halt) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        RUN: begin
          if (bus.halt) begin
            state_q    <= IDLE;
            instruct_q <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pc_q       <= '0;
            cnt_q      <= '0;
          end else if (!last_hold_d) begin
            cnt_q <= cnt_q + CW'(1);
          end else if (!last_entry_d) begin
            pc_q       <= pc_next_d;
            instruct_q <= mem_q[pc_next_d];
            cnt_q      <= '0;
          end else if (bus.loop) begin
            pc_q       <= '0;
            instruct_q <= mem_q[0];
            cnt_q      <= '0;
          end else begin
            state_q    <= DONE;
            instruct_q <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            pc_q       <= '0;
            cnt_q      <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.instruct    = instruct_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - self-checking bench for instruction_sequencer
// Expected per-cycle outputs are queued when a run is launched and popped each cycle.
module tb_instruction_sequencer;
  localparam int DEPTH = 8;
  localparam int HOLD  = 7;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instruction_sequencer_if #(.DEPTH(DEPTH)) bus ();
  instruction_sequencer #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [8:0]    instr;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
  } exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [2:0]    op;
    logic [2:0]    so;
    logic [2:0]    si;
    logic [8:0]    word;
  } vec_t;

  typedef enum {A_NONE, A_LOOP0, A_HALT, A_START, A_WRITE, A_RESET} act_t;

  exp_t       sb [$];
  vec_t       vecs [DEPTH];
  logic [8:0] model_mem [DEPTH];
  int         tests = 0;
  int         fails = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(logic [8:0] w, logic [AW-1:0] p, logic b, logic d);
    exp_t e;
    e.instr = w;
    e.pc    = p;
    e.busy  = b;
    e.done  = d;
    return e;
  endfunction

  task automatic check(input string name, input exp_t e);
    tests++;
    if (bus.instruct !== e.instr || bus.pc !== e.pc || bus.instr_valid !== e.busy ||
        bus.busy !== e.busy || bus.done !== e.done) begin
      fails++;
      $display("FAIL %s: got instruct=%h pc=%0d valid=%b busy=%b done=%b, want instruct=%h pc=%0d valid=%b busy=%b done=%b",
               name, bus.instruct, bus.pc, bus.instr_valid, bus.busy, bus.done,
               e.instr, e.pc, e.busy, e.busy, e.done);
    end
  endtask

  task automatic push_cycles(input int len, input int n);
    for (int c = 0; c < n; c++) begin
      int p;
      p = (c / HOLD) % len;
      sb.push_back(mk(model_mem[p], AW'(p), 1'b1, 1'b0));
    end
  endtask

  task automatic push_done();
    sb.push_back(mk(9'h000, '0, 1'b0, 1'b1));
  endtask

  task automatic push_idle();
    sb.push_back(mk(9'h000, '0, 1'b0, 1'b0));
  endtask

  task automatic start_run(input int len);
    bus.prog_len = (AW+1)'(len);
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
  endtask

  task automatic write_entry(input logic [AW-1:0] a, input logic [2:0] op,
                             input logic [2:0] so, input logic [2:0] si);
    bus.wr_en      = 1'b1;
    bus.wr_addr    = a;
    bus.wr_op      = op;
    bus.wr_sel_out = so;
    bus.wr_sel_in  = si;
    tick();
    bus.wr_en      = 1'b0;
  endtask

  task automatic apply(input act_t a);
    case (a)
      A_LOOP0: bus.loop = 1'b0;
      A_HALT:  bus.halt = 1'b1;
      A_START: begin
        bus.start    = 1'b1;
        bus.prog_len = 4'd1;
      end
      A_WRITE: begin
        bus.wr_en      = 1'b1;
        bus.wr_addr    = 3'd1;
        bus.wr_op      = 3'd7;
        bus.wr_sel_out = 3'd7;
        bus.wr_sel_in  = 3'd7;
      end
      A_RESET: reset = 1'b1;
      default: ;
    endcase
  endtask

  // Cycle k is the k-th sample after the launching edge; actions drive the edge after it.
  task automatic drain(input string name, input act_t a1, input int k1,
                       input act_t a2, input int k2);
    int   k;
    exp_t e;
    k = 1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("%s c%0d", name, k), e);
      bus.start = 1'b0;
      bus.halt  = 1'b0;
      bus.wr_en = 1'b0;
      reset     = 1'b0;
      if (k == k1) apply(a1);
      if (k == k2) apply(a2);
      if (sb.size() > 0) tick();
      k++;
    end
    bus.start = 1'b0;
    bus.halt  = 1'b0;
    bus.wr_en = 1'b0;
    reset     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{3'd0, 3'd7, 3'd6, 3'd4, 9'h1F4};
    vecs[1] = '{3'd1, 3'd4, 3'd6, 3'd4, 9'h134};
    vecs[2] = '{3'd2, 3'd3, 3'd3, 3'd4, 9'h0DC};
    vecs[3] = '{3'd3, 3'd1, 3'd2, 3'd3, 9'h053};
    vecs[4] = '{3'd4, 3'd5, 3'd0, 3'd7, 9'h147};
    vecs[5] = '{3'd5, 3'd2, 3'd5, 3'd1, 9'h0A9};
    vecs[6] = '{3'd6, 3'd6, 3'd1, 3'd6, 9'h18E};
    vecs[7] = '{3'd7, 3'd0, 3'd7, 3'd2, 9'h03A};
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 9'h000;

    reset = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_op = '0; bus.wr_sel_out = '0; bus.wr_sel_in = '0;
    bus.prog_len = '0; bus.start = 1'b0; bus.loop = 1'b0; bus.halt = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("reset", mk(9'h000, '0, 1'b0, 1'b0));

    start_run(1);
    push_cycles(1, HOLD); push_done();
    drain("len1_cleared", A_NONE, 0, A_NONE, 0);

    for (int i = 0; i < DEPTH; i++) begin
      write_entry(vecs[i].addr, vecs[i].op, vecs[i].so, vecs[i].si);
      model_mem[vecs[i].addr] = vecs[i].word;
    end
    start_run(8);
    push_cycles(8, 8 * HOLD); push_done();
    drain("table_len8", A_NONE, 0, A_NONE, 0);

    start_run(3);
    push_cycles(3, 3 * HOLD); push_done();
    drain("run3", A_NONE, 0, A_NONE, 0);

    bus.prog_len = 4'd0; bus.start = 1'b1; tick(); bus.start = 1'b0;
    check("start_len0", mk(9'h000, '0, 1'b0, 1'b1));
    bus.prog_len = 4'd9; bus.start = 1'b1; tick(); bus.start = 1'b0;
    check("start_len9", mk(9'h000, '0, 1'b0, 1'b1));

    bus.loop = 1'b1;
    start_run(3);
    push_cycles(3, 6 * HOLD); push_done();
    drain("loop", A_LOOP0, 30, A_NONE, 0);

    start_run(3);
    push_cycles(3, 10); push_idle();
    drain("halt_run", A_HALT, 10, A_NONE, 0);
    bus.prog_len = 4'd3; bus.start = 1'b1; bus.halt = 1'b1; tick();
    bus.start = 1'b0; bus.halt = 1'b0;
    check("start_with_halt", mk(9'h000, '0, 1'b0, 1'b0));

    start_run(3);
    push_cycles(3, 3 * HOLD); push_done();
    drain("busy_wr_start", A_WRITE, 3, A_START, 5);
    start_run(3);
    push_cycles(3, 3 * HOLD); push_done();
    drain("after_busy_wr", A_NONE, 0, A_NONE, 0);

    bus.halt = 1'b1; tick(); bus.halt = 1'b0;
    check("halt_in_done", mk(9'h000, '0, 1'b0, 1'b0));

    start_run(3);
    push_cycles(3, 12); push_idle();
    drain("reset_mid", A_RESET, 12, A_NONE, 0);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 9'h000;
    start_run(2);
    push_cycles(2, 2 * HOLD); push_done();
    drain("after_reset", A_NONE, 0, A_NONE, 0);

    bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_op = 3'd7; bus.wr_sel_out = 3'd6; bus.wr_sel_in = 3'd4;
    bus.prog_len = 4'd1; bus.start = 1'b1;
    tick();
    bus.wr_en = 1'b0; bus.start = 1'b0;
    model_mem[0] = 9'h1F4;
    push_cycles(1, HOLD); push_done();
    drain("wr_with_start", A_NONE, 0, A_NONE, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
